snax_simbacore_csr_launcher: RTL
================================

# snax_simbacore_csr_launcher

Control stage directly upstream of the SimbaCore `io_config` port. It sits between the SNAX CSR manager and the core: it accepts one configuration set per job, holds it stable, and issues it to the core with a valid/ready handshake. It then tracks job progress by counting output-stream handshakes against a programmed expected beat count. It also drives the read-only CSRs with busy/done status and the cycle count of the last job.

## Interface

Parameters:

- `RegDataWidth`, 32, width of every CSR word.
- `CfgRegCount`, 5, number of core config words: mode, seqLen, dModel, dtRank, dInner.
- `NumOutPorts`, 4, number of acc2stream ports whose handshakes are counted.

Ports:

- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `csr_reg_set_i`  in  `[CfgRegCount+1][RegDataWidth]`
  - indices 0..4 are core config words;
  - index 5 is the expected total output beats.
- `csr_reg_set_valid_i`  in  1  CSR manager offers a new job.
- `csr_reg_set_ready_o`  out  1  launcher can accept a job.
- `csr_reg_ro_set_o`  out  `[2][RegDataWidth]`
  - word 0 is status;
  - word 1 is the last-job cycle count.
- `core_cfg_o`  out  `[CfgRegCount][RegDataWidth]`  latched config, wired to `io_config_bits_*` in index order.
- `core_cfg_valid_o`  out  1  to `io_config_valid`.
- `core_cfg_ready_i`  in  1  from `io_config_ready`.
- `out_fire_i`  in  `[NumOutPorts]`  per-port `acc2stream_k_valid & acc2stream_k_ready`.
- `busy_o`  out  1  job in flight.

## Operation

FSM states: IDLE, ISSUE, RUN.

IDLE:
- `csr_reg_set_ready_o` = 1.
- On `csr_reg_set_valid_i`:
  - latch all six words;
  - clear the beat counter and cycle counter;
  - clear the done bit;
  - go to ISSUE.

ISSUE:
- `core_cfg_valid_o` = 1 and `core_cfg_o` is held stable from the latched words.
- When `core_cfg_ready_i` = 1, go to RUN.
- Valid never drops before ready.
- `out_fire_i` is ignored in this state.

RUN:
- Each cycle:
  - the beat counter increments by popcount(`out_fire_i`), range 0..NumOutPorts;
  - the cycle counter increments by 1, saturating at 2^32-1.
- Completion is checked each cycle as (beat_cnt + popcount) >= expected, evaluated at 33 bits so there is no wrap.
- On completion:
  - go to IDLE;
  - RO word 1 <= cycle counter + 1, which counts RUN cycles including the completing cycle;
  - set the done bit.

Expected = 0 completes on the first RUN cycle, with RO word 1 = 1.

Beats beyond expected in the completing cycle are discarded. Fires arriving in IDLE do not affect any state.

Status word (RO word 0):
- bit0 = busy (state != IDLE);
- bit1 = done, sticky until the next accepted job;
- bits 31:2 = 0.

`busy_o` equals status bit0.

`csr_reg_set_ready_o` = 0 in ISSUE and RUN. A new job is accepted only from IDLE, including in the cycle right after completion.

## Timing

- Reset (`rst_i` = 1 at a rising edge) forces, from the next cycle:
  - state IDLE;
  - `csr_reg_set_ready_o` = 1;
  - `core_cfg_valid_o` = 0;
  - `busy_o` = 0;
  - `core_cfg_o` = 0;
  - both RO words = 0;
  - all counters = 0.
- Reset mid-job aborts the job without updating RO word 1 and drops `core_cfg_valid_o` at the same edge.
- CSR handshake in cycle t: `core_cfg_valid_o` = 1 and `busy_o` = 1 from cycle t+1.
- Core handshake in cycle u: RUN from cycle u+1; first counted fire cycle is u+1.
- Completing cycle c: `busy_o` = 0, `csr_reg_set_ready_o` = 1 and the RO words are updated from cycle c+1.
- All outputs are registered or decoded from state only. There is no combinational path from `core_cfg_ready_i`, `out_fire_i` or `csr_reg_set_valid_i` to any output.

## Test plan

- Reset then idle: after `rst_i` is held 2 cycles, ready_o=1, valid_o=0, RO0=0, RO1=0.
- Basic job: config {1,64,32,4,128}, expected=8, core ready after 3 cycles, then one fire/cycle on port 0 for 8 cycles.
  - `core_cfg_o` equals the config and is stable through ISSUE.
  - Busy drops exactly after the 8th fire.
  - RO1=8, RO0=0b10.
- Multi-port fires: expected=10, out_fire_i=4'b1111 for 3 cycles.
  - Completes on cycle 3 with an overshoot of 2 discarded.
  - RO1=3.
- Zero beats: expected=0, immediate core ready -> one RUN cycle, RO1=1, done set.
- Backpressure and blocking:
  - Holding `core_cfg_ready_i`=0 for 20 cycles keeps valid_o=1 with stable data.
  - A second `csr_reg_set_valid_i` during RUN sees ready_o=0 and is not latched.
  - Fires during ISSUE are not counted.
- Reset mid-RUN after 5 of 8 beats -> IDLE next cycle, RO1=0, RO0=0.
  - A new job with expected=2 then completes normally with RO1=2.

Source files
------------

// File: rtl/snax_simbacore_csr_launcher.sv
// Launcher between the SNAX CSR manager and the SimbaCore io_config port.
// It latches one job, issues it to the core, then counts output beats until the job is done.
module snax_simbacore_csr_launcher #(
    parameter int RegDataWidth = 32,
    parameter int CfgRegCount  = 5,
    parameter int NumOutPorts  = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [CfgRegCount:0][RegDataWidth-1:0]      csr_reg_set_i,
    input  logic                                        csr_reg_set_valid_i,
    output logic                                        csr_reg_set_ready_o,
    output logic [1:0][RegDataWidth-1:0]                csr_reg_ro_set_o,
    output logic [CfgRegCount-1:0][RegDataWidth-1:0]    core_cfg_o,
    output logic                                        core_cfg_valid_o,
    input  logic                                        core_cfg_ready_i,
    input  logic [NumOutPorts-1:0]                      out_fire_i,
    output logic                                        busy_o
);

    localparam int PopW = $clog2(NumOutPorts + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [RegDataWidth-1:0] expected_q;
    logic [RegDataWidth-1:0] beat_cnt;
    logic [RegDataWidth-1:0] cycle_cnt;
    logic [RegDataWidth-1:0] cycle_inc;
    logic [RegDataWidth-1:0] last_cycles;
    logic                    done;
    logic [PopW-1:0]         fire_count;
    logic [RegDataWidth:0]   beat_sum;
    logic                    accept;
    logic                    complete;

    // The beat sum carries one extra bit so a large expected count never wraps.
    always_comb begin
        fire_count = '0;
        for (int i = 0; i < NumOutPorts; i++) begin
            fire_count = fire_count + PopW'(out_fire_i[i]);
        end
        beat_sum  = {1'b0, beat_cnt} + (RegDataWidth + 1)'(fire_count);
        cycle_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + RegDataWidth'(1);
        accept    = (state == IDLE) && csr_reg_set_valid_i;
        complete  = (state == RUN) && (beat_sum >= {1'b0, expected_q});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (csr_reg_set_valid_i) state_next = ISSUE;
            ISSUE:   if (core_cfg_ready_i) state_next = RUN;
            RUN:     if (complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            core_cfg_o  <= '0;
            expected_q  <= '0;
            beat_cnt    <= '0;
            cycle_cnt   <= '0;
            last_cycles <= '0;
            done        <= 1'b0;
        end else if (accept) begin
            core_cfg_o <= csr_reg_set_i[CfgRegCount-1:0];
            expected_q <= csr_reg_set_i[CfgRegCount];
            beat_cnt   <= '0;
            cycle_cnt  <= '0;
            done       <= 1'b0;
        end else if (state == RUN) begin
            if (complete) begin
                last_cycles <= cycle_inc;
                done        <= 1'b1;
            end else begin
                beat_cnt  <= beat_sum[RegDataWidth-1:0];
                cycle_cnt <= cycle_inc;
            end
        end
    end

    // Every output is a decode of the state register or a flop, never of an input.
    always_comb begin
        csr_reg_set_ready_o    = (state == IDLE);
        core_cfg_valid_o       = (state == ISSUE);
        busy_o                 = (state != IDLE);
        csr_reg_ro_set_o       = '0;
        csr_reg_ro_set_o[0][0] = (state != IDLE);
        csr_reg_ro_set_o[0][1] = done;
        csr_reg_ro_set_o[1]    = last_cycles;
    end

endmodule
